// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: staged reset sequencer with synchronized release and soft reset.
//   clk          - single clock for all logic
//   rstn         - asynchronous active-low hard reset
//   soft_rst_req - soft-reset request, acted on at its rising edge
//   soft_rst_ack - one-cycle pulse when a soft request is accepted
//   rstn_out     - staged active-low resets, bit 0 released first
//   rst_done     - high once every rstn_out bit is released
//   soft_rst_cnt - saturating count of accepted soft resets
module rst_seq_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int NUM_STAGES  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  soft_rst_req,
    output logic                  soft_rst_ack,
    output logic [NUM_STAGES-1:0] rstn_out,
    output logic                  rst_done,
    output logic [7:0]            soft_rst_cnt
);
    localparam int MAXC = HOLD_CYCLES > STAGE_GAP ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
    // idx must be able to hold NUM_STAGES once the last bit is released
    localparam int IW   = $clog2(NUM_STAGES + 1);

    typedef enum logic [1:0] {ASSERT, HOLD, RELEASE, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_rstn;
    logic                   req_q;
    logic                   soft_rise;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;

    assign sync_rstn = sync[SYNC_STAGES-1];
    assign soft_rise = soft_rst_req & ~req_q;

    // assertion is immediate via async clear; release ripples through the chain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            sync <= '0;
        else
            sync <= {sync[SYNC_STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ASSERT;
            req_q        <= 1'b0;
            soft_rst_ack <= 1'b0;
            rstn_out     <= '0;
            rst_done     <= 1'b0;
            soft_rst_cnt <= '0;
            cnt          <= '0;
            idx          <= '0;
        end else begin
            req_q        <= soft_rst_req;
            soft_rst_ack <= 1'b0;
            // a soft request outranks any release due on the same edge
            if (soft_rise && state != ASSERT) begin
                state        <= HOLD;
                rstn_out     <= '0;
                rst_done     <= 1'b0;
                soft_rst_ack <= 1'b1;
                cnt          <= '0;
                idx          <= '0;
                if (soft_rst_cnt != 8'hFF)
                    soft_rst_cnt <= soft_rst_cnt + 8'd1;
            end else begin
                case (state)
                    ASSERT: begin
                        if (sync_rstn) begin
                            state <= HOLD;
                            cnt   <= '0;
                        end
                    end
                    HOLD: begin
                        if (cnt == CW'(HOLD_CYCLES - 1)) begin
                            rstn_out[0] <= 1'b1;
                            cnt         <= '0;
                            idx         <= IW'(1);
                            if (NUM_STAGES == 1) begin
                                state    <= DONE;
                                rst_done <= 1'b1;
                            end else begin
                                state <= RELEASE;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    RELEASE: begin
                        if (cnt == CW'(STAGE_GAP - 1)) begin
                            rstn_out <= rstn_out | (NUM_STAGES'(1) << idx);
                            idx      <= idx + IW'(1);
                            cnt      <= '0;
                            if (idx == IW'(NUM_STAGES - 1)) begin
                                state    <= DONE;
                                rst_done <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
